// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver with 2-flop line synchronizer and mid-bit sampling.
// Optional stop-bit checking: define UART_RX_FRAME_CHECK_EN.
module uart_rx #(
  parameter int clocks_per_bit = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_rx,
  output logic [7:0] out_data,
  output logic       out_valid,
  output logic       out_frame_err,
  output logic       out_busy
);
  localparam int CW = $clog2(clocks_per_bit);
  localparam logic [CW-1:0] HALF_M1 = CW'(clocks_per_bit / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(clocks_per_bit - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

  logic          s1_q, rx_s_q, rx_prev_q;
  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    data_q, data_d;
  logic          valid_q, valid_d;
`ifdef UART_RX_FRAME_CHECK_EN
  logic          ferr_q, ferr_d;
`endif

  logic start_edge;
  assign start_edge = ~rx_s_q & rx_prev_q;

  // Sync flops reset high so a line held low at reset release still yields an edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q      <= 1'b1;
      rx_s_q    <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      s1_q      <= in_rx;
      rx_s_q    <= s1_q;
      rx_prev_q <= rx_s_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
`ifdef UART_RX_FRAME_CHECK_EN
      ferr_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
`ifdef UART_RX_FRAME_CHECK_EN
      ferr_q  <= ferr_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    data_d  = data_q;
    valid_d = 1'b0;
`ifdef UART_RX_FRAME_CHECK_EN
    ferr_d  = 1'b0;
`endif
    unique case (state_q)
      IDLE: begin
        if (start_edge) begin
          state_d = START;
          cnt_d   = HALF_M1;
        end
      end
      START: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else if (!rx_s_q) begin
          state_d = DATA;
          cnt_d   = FULL_M1;
          bit_d   = 3'd0;
        end else begin
          state_d = IDLE;  // start bit gone by mid-bit: glitch
        end
      end
      DATA: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          shift_d = {rx_s_q, shift_q[7:1]};
          cnt_d   = FULL_M1;
          if (bit_q == 3'd7) state_d = STOP;
          else               bit_d   = bit_q + 3'd1;
        end
      end
      STOP: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          state_d = IDLE;
`ifdef UART_RX_FRAME_CHECK_EN
          if (rx_s_q) begin
            data_d  = shift_q;
            valid_d = 1'b1;
          end else begin
            ferr_d  = 1'b1;
          end
`else
          data_d  = shift_q;
          valid_d = 1'b1;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign out_data  = data_q;
  assign out_valid = valid_q;
  assign out_busy  = (state_q != IDLE);
`ifdef UART_RX_FRAME_CHECK_EN
  assign out_frame_err = ferr_q;
`else
  assign out_frame_err = 1'b0;
`endif

endmodule
